// File: rtl/encoder_ctrl_pkg.sv
// Shared opcodes, controller states and the snapshot record layout
// for the encoder command sequencer.
package encoder_ctrl_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_START      = 3'd1;
  localparam logic [2:0] OP_STOP       = 3'd2;
  localparam logic [2:0] OP_CLEAR      = 3'd3;
  localparam logic [2:0] OP_SNAP       = 3'd4;
  localparam logic [2:0] OP_SET_PERIOD = 3'd5;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_CLEARING = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] position;
    logic [31:0] velocity;
    logic        direction;
    logic        is_auto;
  } snap_rec_t;

endpackage

// File: rtl/encoder_snap_buf.sv
// One-entry valid/ready snapshot holding register. A host capture wins over a
// simultaneous auto tick; an auto tick that finds the entry occupied is dropped and flagged.
module encoder_snap_buf
  import encoder_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_host_cap,
  input  logic        i_auto_tick,
  input  logic        i_ovr_clr,
  input  logic        i_ready,
  input  logic [31:0] i_position,
  input  logic [31:0] i_velocity,
  input  logic        i_direction,
  output logic        o_free,
  output logic        o_valid,
  output logic [31:0] o_position,
  output logic [31:0] o_velocity,
  output logic        o_direction,
  output logic        o_auto,
  output logic        o_overrun
);

  snap_rec_t r_rec;
  logic      r_valid;
  logic      r_overrun;
  logic      w_free;
  logic      w_auto_cap;
  logic      w_cap;

  // The entry may be refilled in the same cycle the consumer drains it.
  assign w_free     = !r_valid || i_ready;
  assign w_auto_cap = i_auto_tick && w_free && !i_host_cap;
  assign w_cap      = i_host_cap || w_auto_cap;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_rec     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_cap) begin
        r_valid <= 1'b1;
        r_rec   <= '{position:  i_position,
                     velocity:  i_velocity,
                     direction: i_direction,
                     is_auto:   !i_host_cap};
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end

      if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end else if (i_auto_tick && !w_free) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_free      = w_free;
  assign o_valid     = r_valid;
  assign o_position  = r_rec.position;
  assign o_velocity  = r_rec.velocity;
  assign o_direction = r_rec.direction;
  assign o_auto      = r_rec.is_auto;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/encoder_ctrl.sv
// Command sequencer and snapshot scheduler for one quadrature encoder core.
// Define ENC_CTRL_LIMIT_EN to add the signed position-limit monitor (lim_lo/lim_hi/lim_irq).
module encoder_ctrl
  import encoder_ctrl_pkg::*;
#(
  parameter int CLR_WAIT = 2,
  parameter int PERIOD_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        core_enable,
  output logic        core_clr_pos,
  input  logic [31:0] core_position,
  input  logic [31:0] core_velocity,
  input  logic        core_direction,
  output logic        snap_valid,
  input  logic        snap_ready,
  output logic [31:0] snap_position,
  output logic [31:0] snap_velocity,
  output logic        snap_direction,
  output logic        snap_auto,
  output logic        snap_overrun,
`ifdef ENC_CTRL_LIMIT_EN
  input  logic [31:0] lim_lo,
  input  logic [31:0] lim_hi,
  output logic        lim_irq,
`endif
  output logic        running
);

  localparam int CNT_W = $clog2(CLR_WAIT + 1);

  state_t              r_state, w_state_nxt;
  logic                r_enable, w_enable_nxt;
  logic                r_clr_pos, w_clr_pos_nxt;
  logic [CNT_W-1:0]    r_clr_cnt, w_clr_cnt_nxt;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_count;
  logic                w_buf_free;
  logic                w_cmd_ready;
  logic                w_accept;
  logic                w_clear;
  logic                w_host_cap;
  logic                w_tick;

  assign w_cmd_ready = (r_state != ST_CLEARING) && !((cmd_op == OP_SNAP) && !w_buf_free);
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_clear     = w_accept && (cmd_op == OP_CLEAR);
  assign w_host_cap  = w_accept && (cmd_op == OP_SNAP);
  assign w_tick      = (r_state == ST_RUNNING) && (r_period != '0) &&
                       (r_count == r_period - PERIOD_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_STOPPED;
      r_enable  <= 1'b0;
      r_clr_pos <= 1'b0;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_enable  <= w_enable_nxt;
      r_clr_pos <= w_clr_pos_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // r_enable doubles as the state to return to once a clear has settled.
  always_comb begin
    w_state_nxt   = r_state;
    w_enable_nxt  = r_enable;
    w_clr_pos_nxt = 1'b0;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_STOPPED, ST_RUNNING: begin
        if (w_clear) begin
          w_state_nxt   = ST_CLEARING;
          w_clr_pos_nxt = 1'b1;
          w_clr_cnt_nxt = CNT_W'(CLR_WAIT);
        end else if (w_accept && (cmd_op == OP_START)) begin
          w_state_nxt  = ST_RUNNING;
          w_enable_nxt = 1'b1;
        end else if (w_accept && (cmd_op == OP_STOP)) begin
          w_state_nxt  = ST_STOPPED;
          w_enable_nxt = 1'b0;
        end
      end
      ST_CLEARING: begin
        if (r_clr_cnt == '0) begin
          w_state_nxt = r_enable ? ST_RUNNING : ST_STOPPED;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_period <= '0;
      r_count  <= '0;
    end else if (w_accept && (cmd_op == OP_SET_PERIOD)) begin
      r_period <= cmd_data[PERIOD_W-1:0];
      r_count  <= '0;
    end else if (w_clear || w_tick) begin
      r_count <= '0;
    end else if (r_state == ST_RUNNING) begin
      r_count <= r_count + PERIOD_W'(1);
    end
  end

  encoder_snap_buf u_snap_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_host_cap  (w_host_cap),
    .i_auto_tick (w_tick),
    .i_ovr_clr   (w_clear),
    .i_ready     (snap_ready),
    .i_position  (core_position),
    .i_velocity  (core_velocity),
    .i_direction (core_direction),
    .o_free      (w_buf_free),
    .o_valid     (snap_valid),
    .o_position  (snap_position),
    .o_velocity  (snap_velocity),
    .o_direction (snap_direction),
    .o_auto      (snap_auto),
    .o_overrun   (snap_overrun)
  );

`ifdef ENC_CTRL_LIMIT_EN
  logic r_lim_irq;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lim_irq <= 1'b0;
    end else if (w_clear) begin
      r_lim_irq <= 1'b0;
    end else if ((r_state == ST_RUNNING) &&
                 (($signed(core_position) < $signed(lim_lo)) ||
                  ($signed(core_position) > $signed(lim_hi)))) begin
      r_lim_irq <= 1'b1;
    end
  end

  assign lim_irq = r_lim_irq;
`endif

  assign cmd_ready    = w_cmd_ready;
  assign core_enable  = r_enable;
  assign core_clr_pos = r_clr_pos;
  assign running      = r_enable;

endmodule

// File: tb/tb_encoder_ctrl.sv
// Self-checking bench for encoder_ctrl; snapshots are predicted into a
// scoreboard queue when stimulus is driven and compared when the DUT presents them.
`timescale 1ns/1ps
module tb_encoder_ctrl;
  import encoder_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        core_enable;
  logic        core_clr_pos;
  logic [31:0] core_position;
  logic [31:0] core_velocity;
  logic        core_direction;
  logic        snap_valid;
  logic        snap_ready;
  logic [31:0] snap_position;
  logic [31:0] snap_velocity;
  logic        snap_direction;
  logic        snap_auto;
  logic        snap_overrun;
  logic        running;
`ifdef ENC_CTRL_LIMIT_EN
  logic [31:0] lim_lo;
  logic [31:0] lim_hi;
  logic        lim_irq;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [65:0] sb_q[$];
  logic [65:0] obs;

  always #5 clk = ~clk;

  assign obs = {snap_position, snap_velocity, snap_direction, snap_auto};

  encoder_ctrl #(.CLR_WAIT(2), .PERIOD_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .core_enable    (core_enable),
    .core_clr_pos   (core_clr_pos),
    .core_position  (core_position),
    .core_velocity  (core_velocity),
    .core_direction (core_direction),
    .snap_valid     (snap_valid),
    .snap_ready     (snap_ready),
    .snap_position  (snap_position),
    .snap_velocity  (snap_velocity),
    .snap_direction (snap_direction),
    .snap_auto      (snap_auto),
    .snap_overrun   (snap_overrun),
`ifdef ENC_CTRL_LIMIT_EN
    .lim_lo         (lim_lo),
    .lim_hi         (lim_hi),
    .lim_irq        (lim_irq),
`endif
    .running        (running)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    cmd_valid      = 1'b0;
    cmd_op         = OP_NOP;
    cmd_data       = '0;
    snap_ready     = 1'b0;
    core_position  = '0;
    core_velocity  = '0;
    core_direction = 1'b0;
`ifdef ENC_CTRL_LIMIT_EN
    lim_lo = -32'sd100;
    lim_hi = 32'sd100;
`endif
    repeat (3) step();
    n_cmp++;
    if ({core_enable, core_clr_pos, snap_valid, snap_auto, snap_overrun, running} !== 6'b0) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000",
               {core_enable, core_clr_pos, snap_valid, snap_auto, snap_overrun, running});
    end
    n_cmp++;
    if (obs !== 66'd0) begin
      n_err++;
      $display("[TB] FAIL reset_snap: got %h want 0", obs);
    end
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_start_stop();
    issue(OP_START, 32'd0);
    n_cmp++;
    if ({core_enable, running} !== 2'b11) begin
      n_err++;
      $display("[TB] FAIL start_enable: got %b want 11", {core_enable, running});
    end
    issue(OP_START, 32'd0);
    n_cmp++;
    if (core_enable !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL start_noop: got %b want 1", core_enable);
    end
    issue(OP_STOP, 32'd0);
    n_cmp++;
    if ({core_enable, running} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL stop_enable: got %b want 00", {core_enable, running});
    end
  endtask

  task automatic test_clear();
    issue(OP_START, 32'd0);
    issue(OP_CLEAR, 32'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({core_clr_pos, cmd_ready, core_enable} !== {(i == 0), (i >= 3), 1'b1}) begin
        n_err++;
        $display("[TB] FAIL clear_seq[%0d]: got clr/rdy/en %b want %b", i,
                 {core_clr_pos, cmd_ready, core_enable}, {(i == 0), (i >= 3), 1'b1});
      end
      step();
    end
    issue(OP_STOP, 32'd0);
  endtask

  task automatic test_host_snap();
    snap_ready     = 1'b0;
    core_position  = -32'sd5;
    core_velocity  = 32'sd12;
    core_direction = 1'b1;
    cmd_valid      = 1'b1;
    cmd_op         = OP_SNAP;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL snap_accept: got %b want 1", cmd_ready);
    end
    sb_q.push_back({core_position, core_velocity, core_direction, 1'b0});
    step();
    core_position  = 32'sd77;
    core_velocity  = -32'sd3;
    core_direction = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({snap_valid, cmd_ready} !== 2'b10) begin
        n_err++;
        $display("[TB] FAIL snap_stall[%0d]: got valid/rdy %b want 10", i, {snap_valid, cmd_ready});
      end
      n_cmp++;
      if (obs !== sb_q[0]) begin
        n_err++;
        $display("[TB] FAIL snap_hold[%0d]: got %h want %h", i, obs, sb_q[0]);
      end
      if (i < 2) step();
    end
    snap_ready = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL snap_unstall: got %b want 1", cmd_ready);
    end
    void'(sb_q.pop_front());
    sb_q.push_back({core_position, core_velocity, core_direction, 1'b0});
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    n_cmp++;
    if ({snap_valid, obs} !== {1'b1, sb_q[0]}) begin
      n_err++;
      $display("[TB] FAIL snap_second: got %b/%h want 1/%h", snap_valid, obs, sb_q[0]);
    end
    void'(sb_q.pop_front());
    step();
    n_cmp++;
    if (snap_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL snap_drain: got %b want 0", snap_valid);
    end
  endtask

  task automatic test_back_to_back();
    snap_ready = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = OP_SNAP;
    for (int i = 0; i < 4; i++) begin
      core_position  = 32'(100 + i);
      core_velocity  = 32'(-i);
      core_direction = i[0];
      sb_q.push_back({core_position, core_velocity, core_direction, 1'b0});
      step();
      n_cmp++;
      if ({snap_valid, obs} !== {1'b1, sb_q[0]}) begin
        n_err++;
        $display("[TB] FAIL b2b[%0d]: got %b/%h want 1/%h", i, snap_valid, obs, sb_q[0]);
      end
      void'(sb_q.pop_front());
    end
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    step();
    n_cmp++;
    if (snap_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_drain: got %b want 0", snap_valid);
    end
  endtask

  task automatic test_auto_period();
    int   mcnt;
    logic mvalid;
    logic movr;
    logic tick;
    logic free;
    snap_ready = 1'b1;
    issue(OP_START, 32'd0);
    issue(OP_SET_PERIOD, 32'd4);
    mcnt   = 0;
    mvalid = 1'b0;
    movr   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      snap_ready     = (i < 12);
      core_position  = 32'(1000 + i);
      core_velocity  = 32'(i * 3);
      core_direction = i[0];
      tick = (mcnt == 3);
      free = !mvalid || snap_ready;
      if (mvalid && snap_ready) void'(sb_q.pop_front());
      if (tick && free) begin
        sb_q.push_back({core_position, core_velocity, core_direction, 1'b1});
        mvalid = 1'b1;
      end else if (mvalid && snap_ready) begin
        mvalid = 1'b0;
      end
      if (tick && !free) movr = 1'b1;
      mcnt = tick ? 0 : mcnt + 1;
      step();
      n_cmp++;
      if ({snap_valid, snap_overrun} !== {mvalid, movr}) begin
        n_err++;
        $display("[TB] FAIL auto_flags[%0d]: got valid/ovr %b want %b", i,
                 {snap_valid, snap_overrun}, {mvalid, movr});
      end
      if (mvalid) begin
        n_cmp++;
        if (obs !== sb_q[0]) begin
          n_err++;
          $display("[TB] FAIL auto_data[%0d]: got %h want %h", i, obs, sb_q[0]);
        end
      end
    end
    issue(OP_SET_PERIOD, 32'd0);
    issue(OP_CLEAR, 32'd0);
    repeat (3) step();
    n_cmp++;
    if ({snap_overrun, snap_valid, obs} !== {1'b0, 1'b1, sb_q[0]}) begin
      n_err++;
      $display("[TB] FAIL clear_keeps_buf: got ovr/valid %b data %h want 01 data %h",
               {snap_overrun, snap_valid}, obs, sb_q[0]);
    end
    snap_ready = 1'b1;
    void'(sb_q.pop_front());
    step();
    n_cmp++;
    if (snap_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL auto_drain: got %b want 0", snap_valid);
    end
    issue(OP_STOP, 32'd0);
  endtask

  task automatic test_collision();
    snap_ready = 1'b1;
    issue(OP_START, 32'd0);
    issue(OP_SET_PERIOD, 32'd4);
    repeat (3) step();
    core_position  = -32'sd42;
    core_velocity  = 32'sd9;
    core_direction = 1'b1;
    cmd_valid      = 1'b1;
    cmd_op         = OP_SNAP;
    sb_q.push_back({core_position, core_velocity, core_direction, 1'b0});
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    n_cmp++;
    if ({snap_valid, snap_overrun, obs} !== {1'b1, 1'b0, sb_q[0]}) begin
      n_err++;
      $display("[TB] FAIL collide_snap: got valid/ovr %b data %h want 10 data %h",
               {snap_valid, snap_overrun}, obs, sb_q[0]);
    end
    void'(sb_q.pop_front());
    step();
    n_cmp++;
    if (snap_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL collide_single: got %b want 0", snap_valid);
    end
    issue(OP_SET_PERIOD, 32'd0);
    issue(OP_STOP, 32'd0);
  endtask

  task automatic test_reset_mid_clear();
    issue(OP_START, 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLEAR;
    reset_n   = 1'b0;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    n_cmp++;
    if ({core_clr_pos, core_enable} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL rst_clear_same: got clr/en %b want 00", {core_clr_pos, core_enable});
    end
    reset_n = 1'b1;
    step();
    issue(OP_START, 32'd0);
    issue(OP_CLEAR, 32'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if ({core_clr_pos, core_enable, cmd_ready} !== 3'b001) begin
      n_err++;
      $display("[TB] FAIL rst_mid_clear: got clr/en/rdy %b want 001",
               {core_clr_pos, core_enable, cmd_ready});
    end
    step();
  endtask

`ifdef ENC_CTRL_LIMIT_EN
  task automatic test_limit();
    lim_lo = -32'sd100;
    lim_hi = 32'sd100;
    issue(OP_START, 32'd0);
    for (int p = 98; p <= 101; p++) begin
      core_position = 32'(p);
      step();
      n_cmp++;
      if (lim_irq !== (p > 100)) begin
        n_err++;
        $display("[TB] FAIL lim_ramp[%0d]: got %b want %b", p, lim_irq, (p > 100));
      end
    end
    core_position = 32'sd50;
    repeat (2) step();
    n_cmp++;
    if (lim_irq !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL lim_sticky: got %b want 1", lim_irq);
    end
    issue(OP_CLEAR, 32'd0);
    n_cmp++;
    if (lim_irq !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL lim_clear: got %b want 0", lim_irq);
    end
    repeat (4) step();
  endtask
`endif

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_start_stop();
    test_clear();
    test_host_snap();
    test_back_to_back();
    test_auto_period();
    test_collision();
    test_reset_mid_clear();
`ifdef ENC_CTRL_LIMIT_EN
    test_limit();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
